// File: rtl/multicycle_controller.sv
// Multicycle controller for a small ARM-style core. It sequences the fetch,
// decode, memory, execute and write-back states, keeps an NZCV register and
// a latched condition result, and faults when memory stays unready too long.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_FAULT  = 4'd15
  } state_t;

  // Counter only has to reach MEM_TIMEOUT-1 before the fault takes over.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              condex_q, condex_d;
  logic [3:0]        nzcv_q, nzcv_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic       pcwrite_c, irwrite_c, memwrite_c, regwrite_c, fault_c;
  logic       mem_wait;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  function automatic logic cmd_supported(input logic [3:0] c);
    return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100);
  endfunction

  function automatic logic [1:0] alu_encode(input logic [3:0] c);
    logic [1:0] enc;
    enc = 2'b00;
    case (c)
      4'b0100: enc = 2'b00;
      4'b0010: enc = 2'b01;
      4'b0000: enc = 2'b10;
      4'b1100: enc = 2'b11;
      default: enc = 2'b00;
    endcase
    return enc;
  endfunction

  // Flags are ordered {N, Z, C, V}.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    r = 1'b0;
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy && !z;
      4'b1001: r = !cy || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State, condition, flag and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      condex_q <= 1'b0;
      nzcv_q   <= 4'b0000;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      condex_q <= condex_d;
      nzcv_q   <= nzcv_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state, flag update and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    condex_d   = condex_q;
    nzcv_d     = nzcv_q;
    wait_d     = wait_q;
    mem_wait   = 1'b0;
    pcwrite_c  = 1'b0;
    irwrite_c  = 1'b0;
    memwrite_c = 1'b0;
    regwrite_c = 1'b0;
    fault_c    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;

    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          state_d   = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        condex_d  = cond_eval(Cond, nzcv_q);
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = !cmd_supported(cmd) ? S_FAULT :
                             (Funct[5] ? S_EXECI : S_EXECR);
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
        else          mem_wait = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        memwrite_c = condex_q;
        if (MemReady) state_d = S_FETCH;
        else          mem_wait = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_encode(cmd);
        if (Funct[0] && condex_q) begin
          nzcv_d[3:2] = ALUFlags[3:2];
          // Logical ops leave carry and overflow untouched.
          if (cmd == 4'b0100 || cmd == 4'b0010) nzcv_d[1:0] = ALUFlags[1:0];
        end
        state_d = S_ALUWB;
      end
      S_ALUWB, S_MEMWB: begin
        ResultSrc = (state_q == S_MEMWB) ? 2'b01 : 2'b00;
        // A write to R15 is a jump: redirect it to the PC instead.
        if (condex_q) begin
          if (Rd == 4'd15) pcwrite_c  = 1'b1;
          else             regwrite_c = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcwrite_c = condex_q;
        state_d   = S_FETCH;
      end
      S_FAULT: begin
        fault_c = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (mem_wait) begin
      if (wait_q == WAIT_LAST) state_d = S_FAULT;
      wait_d = wait_q + WAIT_W'(1);
    end
    if (state_d != state_q) wait_d = '0;
  end

  // Strobes are suppressed while reset is held so nothing fires in that cycle.
  assign PCWrite  = pcwrite_c  & rst;
  assign IRWrite  = irwrite_c  & rst;
  assign MemWrite = memwrite_c & rst;
  assign RegWrite = regwrite_c & rst;
  assign Fault    = fault_c    & rst;
  assign State    = state_q;
  assign ImmSrc   = Op;
  assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with a per-cycle expectation queue.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, Fault;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0] State;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  // Strobe vector layout: {PCWrite, IRWrite, MemWrite, RegWrite, Fault}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] PCW  = 5'b10000;
  localparam logic [4:0] IRW  = 5'b01000;
  localparam logic [4:0] MW   = 5'b00100;
  localparam logic [4:0] RW   = 5'b00010;
  localparam logic [4:0] FLT  = 5'b00001;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [4:0] strb;
    int         rs;
    int         alu;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Queue the expectation for this cycle, then compare at the falling edge and
  // return just after the next rising edge, ready to drive the next cycle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [4:0] strb,
                     input int rs = -1, input int alu = -1);
    exp_t e, got;
    logic [4:0] obs;
    e.tag = tag; e.st = st; e.strb = strb; e.rs = rs; e.alu = alu;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {PCWrite, IRWrite, MemWrite, RegWrite, Fault};
    checks++;
    assert (State === got.st) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", got.tag, State, got.st);
    end
    checks++;
    assert (obs === got.strb) else begin
      errors++;
      $error("FAIL %s strobes got %b want %b", got.tag, obs, got.strb);
    end
    if (got.rs >= 0) begin
      checks++;
      assert (ResultSrc === 2'(got.rs)) else begin
        errors++;
        $error("FAIL %s ResultSrc got %0d want %0d", got.tag, ResultSrc, got.rs);
      end
    end
    if (got.alu >= 0) begin
      checks++;
      assert (ALUControl === 2'(got.alu)) else begin
        errors++;
        $error("FAIL %s ALUControl got %0d want %0d", got.tag, ALUControl, got.alu);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r);
    Cond = c; Op = o; Funct = f; Rd = r;
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_fetch"}, 4'd0, PCW | IRW, 2);
    cyc({tag, "_decode"}, 4'd1, NONE, 2);
  endtask

  task automatic branch(input string tag, input logic [3:0] c, input logic taken);
    set_instr(c, 2'b10, 6'b000000, 4'd0);
    fetch_decode(tag);
    cyc({tag, "_branch"}, 4'd9, taken ? PCW : NONE, 2, 0);
  endtask

  task automatic dp(input string tag, input logic [3:0] c, input logic [5:0] f,
                    input logic [3:0] r, input logic [3:0] flags,
                    input int alu, input logic [4:0] wb);
    set_instr(c, 2'b00, f, r);
    ALUFlags = flags;
    fetch_decode(tag);
    cyc({tag, "_exec"}, f[5] ? 4'd7 : 4'd6, NONE, -1, alu);
    cyc({tag, "_aluwb"}, 4'd8, wb, 0, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    cyc({tag, "_rst"}, 4'd0, NONE);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; MemReady = 1'b1; ALUFlags = 4'b0000;
    set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);

    // Reset held with MemReady high: no strobes.
    cyc("reset0", 4'd0, NONE);
    cyc("reset1", 4'd0, NONE);
    rst = 1'b1;

    // FETCH holds while memory is not ready.
    MemReady = 1'b0;
    cyc("fetch_wait0", 4'd0, NONE);
    cyc("fetch_wait1", 4'd0, NONE);
    MemReady = 1'b1;

    // NZCV starts at 0000.
    branch("beq_nt", 4'b0000, 1'b0);
    dp("adds", 4'b1110, 6'b101001, 4'd1, 4'b0100, 0, RW);     // NZCV=0100
    branch("beq_t", 4'b0000, 1'b1);
    branch("bcs_nt", 4'b0010, 1'b0);
    dp("ands", 4'b1110, 6'b000001, 4'd1, 4'b1011, 2, RW);     // NZCV=1000
    branch("bmi_t", 4'b0100, 1'b1);
    branch("bcs_nt2", 4'b0010, 1'b0);
    branch("bne_t", 4'b0001, 1'b1);
    branch("bnv_nt", 4'b1111, 1'b0);
    dp("add_nos", 4'b1110, 6'b001000, 4'd2, 4'b0100, 0, RW);  // flags untouched
    branch("bne_t2", 4'b0001, 1'b1);
    dp("subs", 4'b1110, 6'b000101, 4'd2, 4'b0011, 1, RW);     // NZCV=0011
    branch("bcs_t", 4'b0010, 1'b1);
    branch("blt_t", 4'b1011, 1'b1);
    dp("orrs_skip", 4'b0000, 6'b011001, 4'd2, 4'b1100, 3, NONE); // EQ false
    branch("bmi_nt", 4'b0100, 1'b0);
    dp("add_pc", 4'b1110, 6'b001000, 4'd15, 4'b0000, 0, PCW);

    // LDR with three unready cycles in MEMRD.
    set_instr(4'b1110, 2'b01, 6'b011001, 4'd3);
    fetch_decode("ldr");
    cyc("ldr_memadr", 4'd2, NONE, -1, 0);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ldr_memrd_wait", 4'd3, NONE, -1, 0);
    MemReady = 1'b1;
    cyc("ldr_memrd_done", 4'd3, NONE, -1, 0);
    cyc("ldr_memwb", 4'd4, RW, 1, 0);

    // STR whose condition fails: no MemWrite.
    set_instr(4'b1011, 2'b01, 6'b011000, 4'd3);              // LT with NZCV=0011: true
    fetch_decode("str_lt");
    cyc("str_lt_memadr", 4'd2, NONE);
    cyc("str_lt_memwr", 4'd5, MW);
    set_instr(4'b0000, 2'b01, 6'b011000, 4'd3);              // EQ false
    fetch_decode("str_eq");
    cyc("str_eq_memadr", 4'd2, NONE);
    cyc("str_eq_memwr", 4'd5, NONE);

    // STR timing out in MEMWR.
    set_instr(4'b1110, 2'b01, 6'b011000, 4'd3);
    fetch_decode("str_to");
    cyc("str_to_memadr", 4'd2, NONE);
    MemReady = 1'b0;
    for (int i = 0; i < 16; i++) cyc("str_to_memwr", 4'd5, MW);
    cyc("str_to_fault", 4'd15, FLT);
    MemReady = 1'b1;
    cyc("str_to_fault_hold", 4'd15, FLT);
    pulse_reset("str_to");

    // Op=11 faults; a single reset cycle recovers.
    set_instr(4'b1110, 2'b11, 6'b000000, 4'd0);
    fetch_decode("op11");
    cyc("op11_fault", 4'd15, FLT);
    cyc("op11_fault_hold", 4'd15, FLT);
    pulse_reset("op11");

    // Unsupported data-processing command (EOR) faults.
    set_instr(4'b1110, 2'b00, 6'b000010, 4'd1);
    fetch_decode("eor");
    cyc("eor_fault", 4'd15, FLT);
    pulse_reset("eor");

    // Reset in the middle of an instruction aborts it and clears NZCV.
    set_instr(4'b1110, 2'b00, 6'b101001, 4'd1);
    ALUFlags = 4'b0010;
    fetch_decode("abort");
    rst = 1'b0;
    cyc("abort_rst", 4'd0, NONE);
    rst = 1'b1;
    branch("bcs_after_rst", 4'b0010, 1'b0);

    // FETCH timeout.
    MemReady = 1'b0;
    for (int i = 0; i < 16; i++) cyc("fetch_to_wait", 4'd0, NONE);
    cyc("fetch_to_fault", 4'd15, FLT);
    MemReady = 1'b1;
    pulse_reset("fetch_to");
    cyc("fetch_after_to", 4'd0, PCW | IRW, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of consecutive MemReady=0 cycles in any memory state before the block faults.
REQ-002 SHALL have clk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have Cond  in  4  instruction condition field, bits [31:28].
REQ-005 SHALL have Op  in  2  instruction class, bits [27:26].
REQ-006 SHALL have Funct  in  6  bits [25:20]: I, cmd[3:0], S/L.
REQ-007 SHALL have Rd  in  4  destination register, bits [15:12].
REQ-008 SHALL have ALUFlags  in  4  NZCV from the ALU.
REQ-009 SHALL have MemReady  in  1  the memory completes the current access this cycle.
REQ-010 SHALL have these outputs: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA (each 1 bit); ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc (each 2 bits); Fault (1); State (4), the current state encoding.

Function
REQ-011 SHALL implement these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, FAULT=15.
REQ-012 FETCH SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ResultSrc=2; it asserts IRWrite and PCWrite only in the cycle MemReady=1, moves to DECODE on that cycle, and otherwise holds.
REQ-013 DECODE SHALL drive ALUSrcA=1, ALUSrcB=2, ResultSrc=2, and SHALL latch CondEx (per REQ-020) into an internal register used by every later state of the instruction.
REQ-014 DECODE transitions SHALL be: Op=01 -> MEMADR; Op=00 with a supported cmd -> EXECR if Funct[5]=0, else EXECI; Op=10 -> BRANCH; Op=11 or an unsupported cmd -> FAULT.
REQ-015 Supported cmd values and their ALUControl encodings SHALL be ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11; ALUControl SHALL be 00 in every state other than EXECR and EXECI.
REQ-016 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=1, ALUControl=00, then go to MEMRD if Funct[0]=1, else MEMWR.
REQ-017 MEMRD and MEMWR SHALL drive AdrSrc=1; MEMWR SHALL drive MemWrite=CondEx on every cycle of the state; both states hold until MemReady=1, after which MEMRD -> MEMWB and MEMWR -> FETCH.
REQ-018 EXECR/EXECI SHALL drive ALUSrcA=0, with ALUSrcB=0 in EXECR and 1 in EXECI, then go to ALUWB; ALUWB and MEMWB SHALL drive RegWrite=CondEx, ResultSrc=0 in ALUWB and 1 in MEMWB, then go to FETCH.
REQ-019 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=1, ResultSrc=2, PCWrite=CondEx, then go to FETCH.
REQ-020 CondEx SHALL be evaluated against the internal NZCV register:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V
- GT !Z&(N==V), LE Z|(N!=V), AL 1
- Cond=1111 SHALL evaluate as 0.
REQ-021 The internal NZCV register SHALL load from ALUFlags at the end of EXECR/EXECI only when Funct[0]=1 and CondEx=1; NZ SHALL always load in that case, and CV SHALL load only for ADD/SUB.
REQ-022 In ALUWB or MEMWB, when Rd=15 and CondEx=1, PCWrite SHALL be asserted and RegWrite SHALL be deasserted.
REQ-023 ImmSrc SHALL equal Op (combinational); RegSrc[0] SHALL be (Op==10) and RegSrc[1] SHALL be (Op==01).
REQ-024 A wait counter SHALL clear on every state change and increment on each MemReady=0 cycle in FETCH, MEMRD or MEMWR; when MemReady=0 and the count equals MEM_TIMEOUT-1, the next state SHALL be FAULT; MemReady=1 in that same cycle SHALL complete the access normally.
REQ-025 FAULT SHALL assert Fault=1 and hold every strobe at 0 until reset.
REQ-026 Latencies with MemReady tied to 1 SHALL be: LDR 5 cycles, STR 4, data-processing 4, B 3.

Reset
REQ-027 While rst=0, State SHALL be FETCH, NZCV, the CondEx register and the wait counter SHALL be 0, and PCWrite, IRWrite, MemWrite, RegWrite and Fault SHALL be 0 regardless of MemReady.
REQ-028 Reset asserted mid-instruction SHALL abort it immediately, and no strobe SHALL fire in the reset cycle.
REQ-029 After rst rises, the first FETCH SHALL complete on the first cycle in which MemReady=1.

Verification
REQ-030 A bench SHALL cover: MemReady=1, ADDS (Cond=1110, Funct=101001, Rd=1) with ALUFlags=0100 -> states 0,1,7,8,0; RegWrite=1 in the ALUWB cycle; NZCV=0100 afterwards.
REQ-031 A bench SHALL cover: BEQ (Cond=0000, Op=10) with NZCV Z=0 -> states 0,1,9,0 with PCWrite=0 in BRANCH; the same with Z=1 -> PCWrite=1.
REQ-032 A bench SHALL cover: LDR (Op=01, Funct[0]=1) with MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegWrite=1 and ResultSrc=1.
REQ-033 A bench SHALL cover: STR with MemReady held at 0 and MEM_TIMEOUT=16 -> MemWrite=1 for 16 cycles, then State=15 and Fault=1.
REQ-034 A bench SHALL cover: Op=11 decoded -> FAULT; then rst=0 for one cycle -> State=0, Fault=0, every strobe 0.
REQ-035 A bench SHALL cover: data-processing instruction with Rd=15 and Cond=AL -> ALUWB drives PCWrite=1 and RegWrite=0.
